// File: rtl/stackcalc_feeder_if.sv
// Host/calculator-side bundle for stackcalc_feeder: program write handshake, run control,
// result capture, and the calculator's 8-bit pin pair.
interface stackcalc_feeder_if #(
  parameter int DEPTH = 8
);
  localparam int CTW = $clog2(DEPTH) + 1;

  logic           wr_valid;
  logic [3:0]     wr_data;
  logic           wr_ready;
  logic           start;
  logic           busy;
  logic           done;
  logic [7:0]     result;
  logic [CTW-1:0] count;
  logic [7:0]     calc_io_in;
  logic [7:0]     calc_io_out;

  modport master (
    output wr_valid, wr_data, start, calc_io_out,
    input  wr_ready, busy, done, result, count, calc_io_in
  );

  modport slave (
    input  wr_valid, wr_data, start, calc_io_out,
    output wr_ready, busy, done, result, count, calc_io_in
  );
endinterface

// File: rtl/stackcalc_feeder.sv
// Buffers host nibbles, then resets and clocks them into the stack calculator; run takes 2*HALF*(RST_TICKS+N)+2 cycles to done.
// Backpressure: wr_ready drops while busy or full; writes offered then are not taken.
module stackcalc_feeder #(
  parameter int DEPTH     = 8,
  parameter int HALF      = 1,
  parameter int RST_TICKS = 2
) (
  input  logic              clk,
  input  logic              rst,
  stackcalc_feeder_if.slave bus
);
  localparam int AW      = $clog2(DEPTH);
  localparam int CTW     = AW + 1;
  localparam int RST_CYC = 2 * HALF * RST_TICKS;
  localparam int CW      = $clog2(RST_CYC) + 1;

  localparam logic [CW-1:0]  RST_LOAD  = CW'(RST_CYC - 1);
  localparam logic [CW-1:0]  HALF_LOAD = CW'(HALF - 1);
  localparam logic [CW-1:0]  HALF_W    = CW'(HALF);
  localparam logic [CTW-1:0] FULL      = CTW'(DEPTH);

  typedef enum logic [2:0] {IDLE, RESET, LOW, HIGH, CAPTURE} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [3:0]     mem [DEPTH];
  logic [AW-1:0]  rd_ptr, rd_ptr_nxt, wr_ptr, wr_ptr_nxt;
  logic [CTW-1:0] count, count_nxt;
  logic [7:0]     io_q, io_nxt, result_q;
  logic [3:0]     head_nxt;
  logic           done_q, wr_ready, push, pop, rst_clk;

  assign wr_ready = (state == IDLE) && (count != FULL);
  assign push     = bus.wr_valid && wr_ready;

  // One down-counter times every phase; it is reloaded on each phase entry.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && count != '0) begin
          state_nxt = RESET;
          cnt_nxt   = RST_LOAD;
        end
      end
      RESET: begin
        if (cnt == '0) begin
          state_nxt = LOW;
          cnt_nxt   = HALF_LOAD;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      LOW: begin
        if (cnt == '0) begin
          state_nxt = HIGH;
          cnt_nxt   = HALF_LOAD;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      HIGH: begin
        if (cnt == '0) begin
          pop = 1'b1;
          if (count > CTW'(1)) begin
            state_nxt = LOW;
            cnt_nxt   = HALF_LOAD;
          end else begin
            state_nxt = CAPTURE;
            cnt_nxt   = '0;
          end
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      CAPTURE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pin image is built from next-cycle state so it can be registered glitch-free.
  always_comb begin
    wr_ptr_nxt = wr_ptr + AW'(push);
    rd_ptr_nxt = rd_ptr + AW'(pop);
    count_nxt  = count + CTW'(push) - CTW'(pop);
    head_nxt   = mem[rd_ptr_nxt];
    rst_clk    = ~|((cnt_nxt / HALF_W) & CW'(1));
    io_nxt     = 8'h00;
    case (state_nxt)
      RESET:   io_nxt = {2'b00, 4'h0, 1'b1, rst_clk};
      LOW:     io_nxt = {2'b00, head_nxt, 2'b00};
      HIGH:    io_nxt = {2'b00, head_nxt, 2'b01};
      default: io_nxt = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      io_q     <= 8'h00;
      result_q <= 8'h00;
      done_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      rd_ptr <= rd_ptr_nxt;
      wr_ptr <= wr_ptr_nxt;
      count  <= count_nxt;
      io_q   <= io_nxt;
      done_q <= (state == CAPTURE);
      if (state == CAPTURE) begin
        result_q <= bus.calc_io_out;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  assign bus.wr_ready   = wr_ready;
  assign bus.busy       = (state != IDLE);
  assign bus.done       = done_q;
  assign bus.result     = result_q;
  assign bus.count      = count;
  assign bus.calc_io_in = io_q;
endmodule

// File: tb/tb_stackcalc_feeder.sv
// Randomized bench for stackcalc_feeder: a queue model of the FIFO and a cycle-offset
// formula for the pin waveform of each run.
module tb_stackcalc_feeder;
  localparam int D  = 8;
  localparam int H  = 1;
  localparam int R  = 2;
  localparam int RC = 2 * H * R;

  logic clk = 1'b0;
  logic rst = 1'b0;

  stackcalc_feeder_if #(.DEPTH(D)) bus ();

  stackcalc_feeder #(.DEPTH(D), .HALF(H), .RST_TICKS(R)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int q[$];
  int prog[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected pins k cycles after the start edge, for an n-nibble program in prog.
  function automatic logic [7:0] exp_io(int k, int n);
    int j;
    logic [3:0] nb;
    logic c;
    if (k <= RC) begin
      c = (((k - 1) / H) % 2) == 1;
      return {2'b00, 4'h0, 1'b1, c};
    end
    if (k <= RC + 2 * H * n) begin
      j  = k - RC - 1;
      nb = 4'(prog[j / (2 * H)]);
      c  = (j % (2 * H)) >= H;
      return {2'b00, nb, 1'b0, c};
    end
    return 8'h00;
  endfunction

  task automatic write_nib(input logic [3:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    chk("wr_ready_fill", bus.wr_ready, q.size() < D);
    tick();
    if (q.size() < D) q.push_back(int'(d));
    bus.wr_valid = 1'b0;
    chk("count_fill", bus.count, q.size());
  endtask

  task automatic run_prog(input bit force_cap, input logic [7:0] cap_val, input bit hold_start);
    int n;
    int cap;
    int ce;
    logic [7:0] exp_res;
    n       = q.size();
    prog    = q;
    q.delete();
    cap     = RC + 2 * H * n + 1;
    exp_res = 8'h00;
    bus.start = 1'b1;
    tick();
    if (!hold_start) bus.start = 1'b0;
    for (int k = 1; k <= cap + 2; k++) begin
      bus.calc_io_out = (force_cap && k == cap) ? cap_val : 8'($urandom);
      if (k == cap) exp_res = bus.calc_io_out;
      if (k <= cap) begin
        bus.wr_valid = 1'($urandom);
        bus.wr_data  = 4'($urandom);
      end else begin
        bus.wr_valid = 1'b0;
      end
      if (k <= RC)       ce = n;
      else if (k < cap)  ce = n - (k - RC - 1) / (2 * H);
      else               ce = 0;
      chk("calc_io_in", bus.calc_io_in, exp_io(k, n));
      chk("busy", bus.busy, k <= cap);
      chk("wr_ready_run", bus.wr_ready, k > cap);
      chk("done", bus.done, k == cap + 1);
      chk("count_run", bus.count, ce);
      if (k > cap) chk("result", bus.result, exp_res);
      if (k < cap + 2) tick();
    end
    bus.start    = 1'b0;
    bus.wr_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n_att;
    bus.wr_valid    = 1'b0;
    bus.wr_data     = 4'h0;
    bus.start       = 1'b0;
    bus.calc_io_out = 8'h00;

    #12;
    chk("rst_busy", bus.busy, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_io", bus.calc_io_in, 0);
    chk("rst_wr_ready", bus.wr_ready, 1);
    chk("rst_done", bus.done, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();

    // start with nothing buffered must be ignored
    bus.start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("empty_busy", bus.busy, 0);
      chk("empty_done", bus.done, 0);
      chk("empty_io", bus.calc_io_in, 0);
    end
    bus.start = 1'b0;

    for (int i = 1; i <= 9; i++) write_nib(4'(i));
    chk("full_wr_ready", bus.wr_ready, 0);
    run_prog(1'b0, 8'h00, 1'b0);

    write_nib(4'h3);
    write_nib(4'h5);
    write_nib(4'hA);
    run_prog(1'b1, 8'h5C, 1'b0);

    for (int it = 0; it < 6; it++) begin
      n_att = $urandom_range(1, 10);
      for (int i = 0; i < n_att; i++) begin
        write_nib(4'($urandom));
        if ($urandom_range(0, 3) == 0) tick();
      end
      run_prog(1'b0, 8'h00, 1'($urandom));
    end

    // asynchronous reset during HIGH of the second nibble
    write_nib(4'($urandom));
    write_nib(4'($urandom));
    prog = q;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 1; k < RC + 3 * H + 1; k++) tick();
    chk("pre_rst_io", bus.calc_io_in, exp_io(RC + 3 * H + 1, 2));
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_count", bus.count, 0);
    chk("mid_rst_io", bus.calc_io_in, 0);
    chk("mid_rst_wr_ready", bus.wr_ready, 1);
    chk("mid_rst_result", bus.result, 0);
    chk("mid_rst_done", bus.done, 0);
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();

    write_nib(4'($urandom));
    run_prog(1'b0, 8'h00, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/stackcalc_feeder.md
# stackcalc_feeder

Host-side driver for the stack calculator's 8-bit pin interface. It buffers a program of 4-bit instruction nibbles written by a host, and on `start` does three things: resets the calculator, clocks the program into it one nibble per calculator clock, and captures the calculator's 8-bit output once the program has drained. It sits between a host or bench sequencer and the calculator's `io_in`/`io_out` pins, and generates the calculator's clock and reset from the system clock.

## Interface

Parameters:
- `DEPTH`, 8: program FIFO depth in nibbles; power of two, ≥2.
- `HALF`, 1: system-clock cycles per calculator clock half-period; ≥1.
- `RST_TICKS`, 2: calculator clock periods for which calculator reset is held; ≥1.

Ports:
- `clk` input 1: system clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `wr_valid` input 1: host offers a program nibble.
- `wr_data` input 4: program nibble.
- `wr_ready` output 1: FIFO accepts a nibble; transfer when `wr_valid && wr_ready`.
- `start` input 1: request to run the buffered program; level-sampled.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse when `result` updates.
- `result` output 8: calculator output captured at the end of the run.
- `count` output $clog2(DEPTH)+1: nibbles currently in the FIFO.
- `calc_io_in` output 8: drives calculator pins as {2'b00, nibble[3:0], calc_rst, calc_clk}.
- `calc_io_out` input 8: calculator output pins.

## Operation

- FIFO:
  - Circular buffer with read/write pointers and occupancy `count`.
  - `wr_ready = !busy && count != DEPTH`. Writes are never accepted while `busy`.
  - A write while full is ignored; state is unchanged.
- States: IDLE, RESET, LOW, HIGH, CAPTURE.
- IDLE:
  - `calc_io_in` = 8'h00.
  - If `start && count != 0`, go to RESET.
  - `start` with `count == 0` is ignored: no state change, no `done`.
- RESET:
  - `calc_rst` = 1 and nibble = 0.
  - `calc_clk` toggles every HALF cycles, starting low, for RST_TICKS full periods (2·HALF·RST_TICKS cycles).
  - Then go to LOW.
- LOW:
  - `calc_rst` = 0, `calc_clk` = 0, nibble = FIFO head.
  - Lasts HALF cycles, then go to HIGH.
- HIGH:
  - `calc_clk` = 1; nibble still holds the FIFO head, so it is stable across the calculator's rising edge.
  - Lasts HALF cycles. On the last cycle, pop the FIFO.
  - Next state: LOW if nibbles remain after the pop, else CAPTURE.
- CAPTURE:
  - `calc_io_in` = 8'h00.
  - Lasts one cycle. On its edge, `result <= calc_io_out` and `done` pulses for the following cycle.
  - Go to IDLE.
- A single down-counter, reloaded on each phase entry, times all phases.
- `start` held high across a run re-triggers only if the FIFO is non-empty back in IDLE. It is empty after a run unless refilled.
- Reset: asynchronous, at any time including mid-run.
  - State = IDLE, FIFO emptied (`count` = 0), `result` = 8'h00.
  - `done` = 0, `busy` = 0, `calc_io_in` = 8'h00.
  - `wr_ready` = 1 during and after reset.

## Timing

- `start` sampled high at edge T → RESET occupies cycles T+1 … T+2·HALF·RST_TICKS.
- N nibbles take 2·HALF·N cycles in LOW/HIGH. The first LOW begins at T+1+2·HALF·RST_TICKS.
- CAPTURE is the single cycle after the last HIGH. `result`/`done` are visible the cycle after CAPTURE.
- `done` is high exactly one cycle, coincident with the first cycle back in IDLE.
- Total run, `start` edge to `done` high: 2·HALF·(RST_TICKS+N) + 2 cycles.
- `count` decrements on the last cycle of each HIGH phase; it reads 0 during CAPTURE.
- `calc_io_in` is registered: no glitches, and it changes only on `clk` edges.

## Test plan

- Reset values: assert `rst`=0 mid-stream → `busy`=0, `count`=0, `result`=8'h00, `calc_io_in`=8'h00, `wr_ready`=1.
- Fill to full (DEPTH=8): write 9 nibbles 0x1…0x9 → first 8 accepted; `wr_ready`=0 with `count`=8; the 9th is dropped.
- Run with HALF=1, RST_TICKS=2, program {0x3,0x5,0xA}:
  - `calc_rst` high for 4 cycles with `calc_clk` 0,1,0,1.
  - Then nibbles 3, 5, A each held for 2 cycles, with `calc_clk` rising in the second cycle of each.
  - `done` at `start`+12. `result` equals `calc_io_out` sampled in CAPTURE (bench drives 8'h5C → `result`=8'h5C).
- `start` with empty FIFO → stays IDLE; `busy`, `done`, `calc_io_in` remain 0.
- `wr_valid` during run → `wr_ready`=0, no write; `count` does not change beyond pops.
- `rst`=0 during HIGH of second nibble → immediate IDLE, FIFO empty, `calc_io_in`=0. A subsequent 1-nibble run completes normally with `done` at `start`+8 (HALF=1, RST_TICKS=2).
